// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  // Encodings match the RV32M Funct3 field directly.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // DIV and REM are the signed divide ops: Funct3[2]=1, Funct3[0]=0.
  function automatic logic is_signed_div(input logic [2:0] f);
    return f[2] && !f[0];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// Latency: WIDTH cycles after start; done is combinational during the last iteration.
// Backpressure: none; start is honoured only by the owner, abort cancels at the next edge.
//   Ports: clk, reset (async high), start (load operands), abort (cancel),
//   dividend/divisor (magnitudes), busy, done, quotient/remainder (valid while done=1).
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;   // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] r_r;   // partial remainder, always < divisor
  logic [WIDTH-1:0] d_r;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;

  // r_sh < 2*divisor, so the top bit of the WIDTH+1 difference is a clean borrow flag.
  assign r_sh  = {r_r, q_r[WIDTH-1]};
  assign diff  = r_sh - {1'b0, d_r};
  assign fits  = !diff[WIDTH];
  assign q_nxt = {q_r[WIDTH-2:0], fits};
  assign r_nxt = fits ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];

  // Results are exposed one step early so the owner can register them on the final edge.
  assign done      = busy && (cnt == CW'(WIDTH - 1));
  assign quotient  = q_nxt;
  assign remainder = r_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      q_r  <= '0;
      r_r  <= '0;
      d_r  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      q_r  <= dividend;
      r_r  <= '0;
      d_r  <= divisor;
    end else if (busy) begin
      q_r <= q_nxt;
      r_r <= r_nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit sitting beside the EX-stage ALU.
// Latency: MUL* MUL_LATENCY+1, DIV/REM WIDTH+1, div-by-zero/overflow 1 (accept edge to done sample).
// Backpressure: stall holds IF/ID/EX from accept until the S_DONE cycle; one idle bubble after.
//   Ports: clk, reset (async high), start (level, valid M-op), flush (sync abort),
//   Funct3 (op select), A/B (rs1/rs2), stall (comb), done (1-cycle pulse), Result (held).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  md_op_t           op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             negq_q, negr_q;
  logic [1:0]       mcnt;

  // ---------------- accept-side decode (on live inputs) ----------------
  logic             accept, sdiv_in, b_zero, ovf, special;
  logic [WIDTH-1:0] special_res, a_mag, b_mag;

  assign accept  = (state_q == S_IDLE) && start && !flush;
  assign sdiv_in = is_signed_div(Funct3);
  assign b_zero  = (B == '0);
  assign ovf     = sdiv_in && (A == MIN_VAL) && (B == '1);
  assign special = Funct3[2] && (b_zero || ovf);

  // Funct3[1] selects remainder among the divide ops.
  always_comb begin
    if (b_zero) special_res = Funct3[1] ? A : '1;
    else        special_res = Funct3[1] ? '0 : MIN_VAL;
  end

  assign a_mag = (sdiv_in && A[WIDTH-1]) ? -A : A;
  assign b_mag = (sdiv_in && B[WIDTH-1]) ? -B : B;

  // ---------------- divider ----------------
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_q, div_r, q_fix, r_fix, div_res;

  muldiv_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && Funct3[2] && !special),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign q_fix   = negq_q ? -div_q : div_q;
  assign r_fix   = negr_q ? -div_r : div_r;
  assign div_res = op_q[1] ? r_fix : q_fix;

  // ---------------- multiplier ----------------
  // Operands are sign/zero-extended to 2*WIDTH; the low 2*WIDTH bits of an unsigned
  // product of extended values equal the signed product for every signedness mix.
  logic               a_sgn, b_sgn, mul_last;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   mul_res;

  assign a_sgn    = (op_q != OP_MULHU);
  assign b_sgn    = (op_q == OP_MUL) || (op_q == OP_MULH);
  assign a_ext    = {{WIDTH{a_sgn && a_q[WIDTH-1]}}, a_q};
  assign b_ext    = {{WIDTH{b_sgn && b_q[WIDTH-1]}}, b_q};
  assign prod     = a_ext * b_ext;
  assign mul_res  = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  assign mul_last = (mcnt == 2'(MUL_LATENCY - 1));

  // ---------------- FSM ----------------
  logic             result_we;
  logic [WIDTH-1:0] result_d;

  always_comb begin
    state_d   = state_q;
    result_we = 1'b0;
    result_d  = special_res;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (special) begin
            state_d   = S_DONE;
            result_we = 1'b1;
          end else if (Funct3[2]) begin
            state_d = S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mul_last) begin
          state_d   = S_DONE;
          result_we = 1'b1;
          result_d  = mul_res;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (div_done) begin
          state_d   = S_DONE;
          result_we = 1'b1;
          result_d  = div_res;
        end else if (!div_busy) begin
          // Divider lost its operation; never wait forever on it.
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign stall = accept || (state_q == S_MUL) || (state_q == S_DIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      mcnt    <= '0;
      done    <= 1'b0;
      Result  <= '0;
    end else begin
      state_q <= state_d;
      // S_DONE is only reachable from a completing op, so this is a single-cycle pulse.
      done    <= (state_d == S_DONE);
      if (result_we) Result <= result_d;
      if (accept) begin
        op_q   <= md_op_t'(Funct3);
        a_q    <= A;
        b_q    <= B;
        negq_q <= sdiv_in && (A[WIDTH-1] ^ B[WIDTH-1]);
        negr_q <= sdiv_in && A[WIDTH-1];
        mcnt   <= '0;
      end else if (state_q == S_MUL) begin
        mcnt <= mcnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_LATENCY=1).
// Driver pushes expected results to a scoreboard queue; a negedge monitor checks every done.
// Also checks stall duration, flush/reset behaviour and that no stray done appears.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        stall, done;
  logic [31:0] Result;

  muldiv_unit #(.WIDTH(32), .MUL_LATENCY(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .Funct3 (Funct3),
    .A      (A),
    .B      (B),
    .stall  (stall),
    .done   (done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_exp = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 Result=%h expected no done", Result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_result"}, Result, e.res);
        chk({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
      end
    end
  end

  // Issue one op as the pipeline would: start held while stall=1, dropped in S_DONE.
  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1; flush = 1'b0; Funct3 = f; A = a; B = b;
    #1;
    chk({nm, "_stall_accept"}, stall, 1);
    e.res = er; e.acc = cyc + 1; e.lat = lat; e.name = nm;
    sbq.push_back(e);
    last_exp = er;
    @(posedge clk);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    start = 1'b0;
    chk({nm, "_stall_cycles"}, n, lat - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_done", done, 0);
    chk("rst_result", Result, 0);
    chk("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue("mul_7_m3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    issue("mulh",       3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
    issue("mulhsu",     3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    issue("mulhu",      3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 2);
    issue("mul_big",    3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 2);
    issue("div_m20_3",  3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33);
    issue("rem_m20_3",  3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33);
    issue("div_20_m3",  3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    issue("rem_20_m3",  3'b110, 32'd20,       32'hFFFFFFFD, 32'h00000002, 33);
    issue("divu_max_2", 3'b101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);
    issue("remu_max10", 3'b111, 32'hFFFFFFFF, 32'd10,       32'h00000005, 33);
    issue("divu_by0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    issue("remu_by0",   3'b111, 32'd5,        32'd0,        32'h00000005, 1);
    issue("rem_by0",    3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    issue("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    issue("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Flush in the middle of a DIV: back to idle, no done, Result untouched.
    @(negedge clk);
    start = 1'b1; Funct3 = 3'b100; A = 32'hFFFFFFEC; B = 32'd3;
    @(posedge clk);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall_before", stall, 1);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_stall_after", stall, 0);
    chk("flush_done", done, 0);
    chk("flush_result", Result, last_exp);
    repeat (40) @(negedge clk);
    chk("flush_result_hold", Result, last_exp);

    // Flush together with start in idle: nothing is accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; Funct3 = 3'b101; A = 32'd100; B = 32'd7;
    #1;
    chk("idle_flush_stall", stall, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush_no_accept", stall, 0);

    issue("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    // Asynchronous reset in the middle of a DIVU.
    @(negedge clk);
    start = 1'b1; Funct3 = 3'b101; A = 32'd1000; B = 32'd3;
    @(posedge clk);
    repeat (4) @(negedge clk);
    #2;
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_result", Result, 0);
    chk("midrst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    last_exp = '0;

    issue("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
